// File: rtl/alu_top_level.sv
// Execute-stage datapath: 16x32 register bank (2R/1W, registered reads, write-first bypass)
// feeding a registered 4-bit-opcode ALU. Optional flags outputs under `ALU_FLAGS_EN.
module alu_top_level #(
  parameter int WIDTH = 32,
  parameter int NREGS = 16,
  localparam int AW = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             read_port_1,
  input  logic             read_port_2,
  input  logic             write_port,
  input  logic [AW-1:0]    addr_port_1,
  input  logic [AW-1:0]    addr_port_2,
  input  logic [AW-1:0]    addr_port_write,
  input  logic [WIDTH-1:0] din_port_write,
  output logic [WIDTH-1:0] dout_port_1,
  output logic [WIDTH-1:0] dout_port_2,
  input  logic [WIDTH-1:0] imm,
  input  logic             op2_sel,
  input  logic [3:0]       alu_op,
  output logic [WIDTH-1:0] result
`ifdef ALU_FLAGS_EN
  ,
  output logic             zero,
  output logic             carry,
  output logic             overflow,
  output logic             negative
`endif
);

  localparam int SW = $clog2(WIDTH);

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_NOT = 4'd5;
  localparam logic [3:0] OP_SLA = 4'd6;
  localparam logic [3:0] OP_SRA = 4'd7;
  localparam logic [3:0] OP_SRL = 4'd8;
  localparam logic [3:0] OP_INC = 4'd9;
  localparam logic [3:0] OP_DEC = 4'd10;
  localparam logic [3:0] OP_HAM = 4'd11;
  localparam logic [3:0] OP_SLT = 4'd12;

  logic [WIDTH-1:0] regs [NREGS];
  logic [WIDTH-1:0] rd_val_1, rd_val_2;
  logic [WIDTH-1:0] op1, op2, alu_res;
  logic [SW-1:0]    shamt;
  logic             write_en;

  // R0 is never written, so it stays at its reset value of zero.
  assign write_en = write_port && (addr_port_write != '0);

  // Read muxes: R0 reads 0; a same-cycle write to the read address wins (write-first).
  always_comb begin
    rd_val_1 = '0;
    if (addr_port_1 != '0) begin
      if (write_en && (addr_port_write == addr_port_1)) rd_val_1 = din_port_write;
      else                                              rd_val_1 = regs[addr_port_1];
    end
  end

  always_comb begin
    rd_val_2 = '0;
    if (addr_port_2 != '0) begin
      if (write_en && (addr_port_write == addr_port_2)) rd_val_2 = din_port_write;
      else                                              rd_val_2 = regs[addr_port_2];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      dout_port_1 <= '0;
      dout_port_2 <= '0;
    end else begin
      if (write_en)    regs[addr_port_write] <= din_port_write;
      if (read_port_1) dout_port_1 <= rd_val_1;
      if (read_port_2) dout_port_2 <= rd_val_2;
    end
  end

  assign op1   = dout_port_1;
  assign op2   = op2_sel ? imm : dout_port_2;
  assign shamt = op2[SW-1:0];

  always_comb begin
    alu_res = '0;
    case (alu_op)
      OP_ADD: alu_res = op1 + op2;
      OP_SUB: alu_res = op1 - op2;
      OP_AND: alu_res = op1 & op2;
      OP_OR:  alu_res = op1 | op2;
      OP_XOR: alu_res = op1 ^ op2;
      OP_NOT: alu_res = ~op1;
      OP_SLA: alu_res = op1 << shamt;
      OP_SRA: alu_res = $unsigned($signed(op1) >>> shamt);
      OP_SRL: alu_res = op1 >> shamt;
      OP_INC: alu_res = op1 + 1'b1;
      OP_DEC: alu_res = op1 - 1'b1;
      OP_HAM: for (int i = 0; i < WIDTH; i++) alu_res = alu_res + {{(WIDTH-1){1'b0}}, op1[i]};
      OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, ($signed(op1) < $signed(op2))};
      default: alu_res = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) result <= '0;
    else      result <= alu_res;
  end

`ifdef ALU_FLAGS_EN
  logic carry_nxt, overflow_nxt;

  // carry is carry-out for ADD/INC and borrow for SUB/DEC.
  always_comb begin
    carry_nxt    = 1'b0;
    overflow_nxt = 1'b0;
    case (alu_op)
      OP_ADD: begin
        carry_nxt    = alu_res < op1;
        overflow_nxt = (op1[WIDTH-1] == op2[WIDTH-1]) && (alu_res[WIDTH-1] != op1[WIDTH-1]);
      end
      OP_SUB: begin
        carry_nxt    = op1 < op2;
        overflow_nxt = (op1[WIDTH-1] != op2[WIDTH-1]) && (alu_res[WIDTH-1] != op1[WIDTH-1]);
      end
      OP_INC: begin
        carry_nxt    = &op1;
        overflow_nxt = alu_res[WIDTH-1] && !op1[WIDTH-1];
      end
      OP_DEC: begin
        carry_nxt    = ~|op1;
        overflow_nxt = op1[WIDTH-1] && !alu_res[WIDTH-1];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      zero     <= 1'b0;
      carry    <= 1'b0;
      overflow <= 1'b0;
      negative <= 1'b0;
    end else begin
      zero     <= (alu_res == '0);
      carry    <= carry_nxt;
      overflow <= overflow_nxt;
      negative <= alu_res[WIDTH-1];
    end
  end
`endif

endmodule

// File: tb/tb_alu_top_level.sv
// Directed bench for alu_top_level: register bank, bypass, ALU ops, flags (when ALU_FLAGS_EN), async reset.
module tb_alu_top_level;

  logic        clk = 1'b0;
  logic        rst;
  logic        read_port_1, read_port_2, write_port;
  logic [3:0]  addr_port_1, addr_port_2, addr_port_write;
  logic [31:0] din_port_write, dout_port_1, dout_port_2, imm, result;
  logic        op2_sel;
  logic [3:0]  alu_op;
`ifdef ALU_FLAGS_EN
  logic        zero, carry, overflow, negative;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_top_level dut (
    .clk(clk), .rst(rst),
    .read_port_1(read_port_1), .read_port_2(read_port_2), .write_port(write_port),
    .addr_port_1(addr_port_1), .addr_port_2(addr_port_2), .addr_port_write(addr_port_write),
    .din_port_write(din_port_write), .dout_port_1(dout_port_1), .dout_port_2(dout_port_2),
    .imm(imm), .op2_sel(op2_sel), .alu_op(alu_op), .result(result)
`ifdef ALU_FLAGS_EN
    , .zero(zero), .carry(carry), .overflow(overflow), .negative(negative)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic write_reg(input logic [3:0] a, input logic [31:0] d);
    write_port = 1'b1; addr_port_write = a; din_port_write = d;
    step();
    write_port = 1'b0;
  endtask

  task automatic read_regs(input logic [3:0] a1, input logic [3:0] a2);
    read_port_1 = 1'b1; read_port_2 = 1'b1; addr_port_1 = a1; addr_port_2 = a2;
    step();
    read_port_1 = 1'b0; read_port_2 = 1'b0;
  endtask

  task automatic run_alu(input string tag, input logic [3:0] a1, input logic [3:0] a2,
                         input logic [3:0] op, input logic sel, input logic [31:0] immv,
                         input logic [31:0] exp);
    alu_op = op; op2_sel = sel; imm = immv;
    read_regs(a1, a2);
    step();
    check_eq(tag, result, exp);
  endtask

  initial begin
    rst = 1'b0;
    read_port_1 = 0; read_port_2 = 0; write_port = 0;
    addr_port_1 = 0; addr_port_2 = 0; addr_port_write = 0;
    din_port_write = 0; imm = 0; op2_sel = 0; alu_op = 0;
    step(); step();
    check_eq("rst_dout1", dout_port_1, 32'h0);
    check_eq("rst_dout2", dout_port_2, 32'h0);
    check_eq("rst_result", result, 32'h0);
    rst = 1'b1;
    step();

    // R0 ignores writes and reads as zero
    write_reg(4'd0, 32'h0000_DEAD);
    read_regs(4'd0, 4'd0);
    check_eq("r0_p1", dout_port_1, 32'h0);
    check_eq("r0_p2", dout_port_2, 32'h0);

    // Write-first bypass on port 1
    write_port = 1'b1; addr_port_write = 4'd5; din_port_write = 32'h0000_1234;
    read_port_1 = 1'b1; addr_port_1 = 4'd5;
    step();
    write_port = 1'b0; read_port_1 = 1'b0;
    check_eq("bypass_p1", dout_port_1, 32'h0000_1234);
    read_regs(4'd0, 4'd5);
    check_eq("r5_p2", dout_port_2, 32'h0000_1234);

    write_reg(4'd1, 32'hFFFF_FFFF);
    write_reg(4'd2, 32'h0000_0001);
    run_alu("add_wrap", 4'd1, 4'd2, 4'd0, 1'b0, 32'h0, 32'h0);
`ifdef ALU_FLAGS_EN
    check_eq("add_carry", {31'b0, carry}, 32'h1);
    check_eq("add_zero", {31'b0, zero}, 32'h1);
    check_eq("add_ovf", {31'b0, overflow}, 32'h0);
`endif
    write_reg(4'd1, 32'h0);
    run_alu("sub_wrap", 4'd1, 4'd2, 4'd1, 1'b0, 32'h0, 32'hFFFF_FFFF);
`ifdef ALU_FLAGS_EN
    check_eq("sub_borrow", {31'b0, carry}, 32'h1);
    check_eq("sub_neg", {31'b0, negative}, 32'h1);
`endif

    write_reg(4'd3, 32'd10);
    run_alu("add_imm", 4'd3, 4'd0, 4'd0, 1'b1, 32'hFFFF_FFFE, 32'd8);

    write_reg(4'd4, 32'h8000_0000);
    run_alu("sra4", 4'd4, 4'd0, 4'd7, 1'b1, 32'd4, 32'hF800_0000);
    run_alu("srl4", 4'd4, 4'd0, 4'd8, 1'b1, 32'd4, 32'h0800_0000);
    run_alu("sla1", 4'd4, 4'd0, 4'd6, 1'b1, 32'd1, 32'h0);
    run_alu("sla0", 4'd5, 4'd0, 4'd6, 1'b1, 32'd0, 32'h0000_1234);
    run_alu("sla4", 4'd5, 4'd0, 4'd6, 1'b1, 32'd4, 32'h0001_2340);
    write_reg(4'd4, 32'hF0F0_F0F0);
    run_alu("ham", 4'd4, 4'd0, 4'd11, 1'b0, 32'h0, 32'd16);

    run_alu("and", 4'd5, 4'd3, 4'd2, 1'b0, 32'h0, 32'h0);
    run_alu("or",  4'd5, 4'd3, 4'd3, 1'b0, 32'h0, 32'h0000_123E);
    run_alu("xor", 4'd5, 4'd5, 4'd4, 1'b0, 32'h0, 32'h0);
    run_alu("not", 4'd3, 4'd0, 4'd5, 1'b0, 32'h0, 32'hFFFF_FFF5);
    run_alu("inc", 4'd1, 4'd0, 4'd9, 1'b0, 32'h0, 32'h1);
    run_alu("dec", 4'd1, 4'd0, 4'd10, 1'b0, 32'h0, 32'hFFFF_FFFF);
`ifdef ALU_FLAGS_EN
    check_eq("dec_borrow", {31'b0, carry}, 32'h1);
`endif
    run_alu("slt_neg", 4'd1, 4'd0, 4'd12, 1'b1, 32'hFFFF_FFFF, 32'h0);
    run_alu("slt_pos", 4'd1, 4'd0, 4'd12, 1'b1, 32'h1, 32'h1);
    run_alu("op13", 4'd5, 4'd3, 4'd13, 1'b0, 32'h0, 32'h0);
    write_reg(4'd6, 32'h7FFF_FFFF);
    run_alu("inc_ovf", 4'd6, 4'd0, 4'd9, 1'b0, 32'h0, 32'h8000_0000);
`ifdef ALU_FLAGS_EN
    check_eq("inc_ovf_flag", {31'b0, overflow}, 32'h1);
    check_eq("inc_carry", {31'b0, carry}, 32'h0);
`endif

    // Read enable low holds dout even when the register changes
    read_regs(4'd5, 4'd6);
    check_eq("hold_pre", dout_port_1, 32'h0000_1234);
    write_reg(4'd5, 32'h0000_5555);
    addr_port_1 = 4'd5;
    step();
    check_eq("hold_p1", dout_port_1, 32'h0000_1234);
    check_eq("hold_p2", dout_port_2, 32'h7FFF_FFFF);
    read_regs(4'd5, 4'd5);
    check_eq("reread_p1", dout_port_1, 32'h0000_5555);

    // Mid-run async reset: outputs clear without a clock edge
    alu_op = 4'd0; op2_sel = 1'b1; imm = 32'h1;
    step();
    check_eq("pre_rst_result", result, 32'h0000_5556);
    #2 rst = 1'b0;
    #1;
    check_eq("async_dout1", dout_port_1, 32'h0);
    check_eq("async_dout2", dout_port_2, 32'h0);
    check_eq("async_result", result, 32'h0);
    step(); step();
    check_eq("held_result", result, 32'h0);
    rst = 1'b1;
    step();
    for (int i = 1; i < 16; i++) begin
      read_regs(4'(i), 4'(16 - i));
      check_eq($sformatf("clr_p1_r%0d", i), dout_port_1, 32'h0);
      check_eq($sformatf("clr_p2_r%0d", 16 - i), dout_port_2, 32'h0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
